// File: rtl/snake_move_ctrl_if.sv
// Interface bundle between the direction decoder / game top level and
// snake_move_ctrl. The controller attaches through the slave modport; the
// host side (game top or bench) uses master.
interface snake_move_ctrl_if #(
  parameter int N       = 8,
  parameter int MAX_LEN = 16
) ();
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          start;
  logic [1:0]    dir_in;
  logic          dir_valid;
  logic [N-1:0]  food_pos;
  logic [N-1:0]  head_out;
  logic          shift_en;
  logic          grow;
  logic [LW-1:0] length;
  logic          game_over;
  logic          running;

  modport master (
    output start, dir_in, dir_valid, food_pos,
    input  head_out, shift_en, grow, length, game_over, running
  );

  modport slave (
    input  start, dir_in, dir_valid, food_pos,
    output head_out, shift_en, grow, length, game_over, running
  );
endinterface

// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: game tick divider, direction latch and head stepper that
// drives the body shift register (head_out -> data_in, shift_en -> enable).
// Optional build macro: SNAKE_WRAP_EN -- coordinates wrap around the field
// edges instead of producing a wall hit.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for start; tick counter held at 0
// RUN   | game active; counter divides clk into ticks, head moves per tick
// DEAD  | wall hit; outputs frozen, game_over high, start restarts the game
module snake_move_ctrl #(
  parameter int N        = 8,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int TICK_DIV = 25000000,
  parameter int START_X  = 2,
  parameter int START_Y  = 2
) (
  input  logic             clk,
  input  logic             reset,
  snake_move_ctrl_if.slave bus
);

  localparam int H  = N / 2;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [N-1:0]  HEAD_INIT = {H'(START_X), H'(START_Y)};
  localparam logic [LW-1:0] LEN_INIT  = LW'(INIT_LEN);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

`ifdef SNAKE_WRAP_EN
  localparam logic WALL_EN = 1'b0;
`else
  localparam logic WALL_EN = 1'b1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cur_dir_q, cur_dir_d;
  logic [1:0]    pend_dir_q, pend_dir_d;
  logic [N-1:0]  head_q, head_d;
  logic [LW-1:0] len_q, len_d;
  logic          shift_en_q, shift_en_d;
  logic          grow_q, grow_d;
  logic          game_over_q, game_over_d;
  logic          running_q, running_d;

  logic          req_ok;
  logic [1:0]    dir_eff;
  logic          tick;
  logic [H-1:0]  cur_x, cur_y, nx, ny;
  logic          edge_hit;
  logic          wall;
  logic [N-1:0]  next_head;
  logic          hit_food;

  // Direction qualification and next-head arithmetic. A request on the tick
  // cycle itself feeds dir_eff so it steers this tick's move.
  always_comb begin
    cur_x    = head_q[N-1:H];
    cur_y    = head_q[H-1:0];
    nx       = cur_x;
    ny       = cur_y;
    edge_hit = 1'b0;
    // Reversal is the opposite direction: flip bit 1 of the code.
    req_ok   = bus.dir_valid && (bus.dir_in != (cur_dir_q ^ 2'b10));
    dir_eff  = req_ok ? bus.dir_in : pend_dir_q;
    tick     = (state_q == S_RUN) && (cnt_q == CNT_LAST);
    case (dir_eff)
      DIR_UP: begin
        ny       = cur_y - 1'b1;
        edge_hit = (cur_y == '0);
      end
      DIR_RIGHT: begin
        nx       = cur_x + 1'b1;
        edge_hit = (cur_x == '1);
      end
      DIR_DOWN: begin
        ny       = cur_y + 1'b1;
        edge_hit = (cur_y == '1);
      end
      default: begin
        nx       = cur_x - 1'b1;
        edge_hit = (cur_x == '0);
      end
    endcase
    wall      = WALL_EN & edge_hit;
    next_head = {nx, ny};
    hit_food  = (next_head == bus.food_pos);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_dir_d   = cur_dir_q;
    pend_dir_d  = pend_dir_q;
    head_d      = head_q;
    len_d       = len_q;
    shift_en_d  = 1'b0;
    grow_d      = 1'b0;
    game_over_d = game_over_q;
    running_d   = running_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d   = S_RUN;
          running_d = 1'b1;
        end
      end
      S_RUN: begin
        if (req_ok) pend_dir_d = bus.dir_in;
        if (tick) begin
          cnt_d      = '0;
          cur_dir_d  = dir_eff;
          pend_dir_d = dir_eff;
          if (wall) begin
            state_d     = S_DEAD;
            game_over_d = 1'b1;
            running_d   = 1'b0;
          end else begin
            head_d     = next_head;
            shift_en_d = 1'b1;
            grow_d     = hit_food;
            if (hit_food && (len_q < LEN_MAX)) len_d = len_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DEAD: begin
        cnt_d = '0;
        // Restart re-initialises everything to its reset value.
        if (bus.start) begin
          state_d     = S_RUN;
          cur_dir_d   = DIR_RIGHT;
          pend_dir_d  = DIR_RIGHT;
          head_d      = HEAD_INIT;
          len_d       = LEN_INIT;
          game_over_d = 1'b0;
          running_d   = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        running_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset takes priority over a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_dir_q   <= DIR_RIGHT;
      pend_dir_q  <= DIR_RIGHT;
      head_q      <= HEAD_INIT;
      len_q       <= LEN_INIT;
      shift_en_q  <= 1'b0;
      grow_q      <= 1'b0;
      game_over_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_dir_q   <= cur_dir_d;
      pend_dir_q  <= pend_dir_d;
      head_q      <= head_d;
      len_q       <= len_d;
      shift_en_q  <= shift_en_d;
      grow_q      <= grow_d;
      game_over_q <= game_over_d;
      running_q   <= running_d;
    end
  end

  assign bus.head_out  = head_q;
  assign bus.shift_en  = shift_en_q;
  assign bus.grow      = grow_q;
  assign bus.length    = len_q;
  assign bus.game_over = game_over_q;
  assign bus.running   = running_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl: three instances (defaults, saturated length,
// left-edge start), scoreboard of expected moves for the main instance.
module tb_snake_move_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  snake_move_ctrl_if #(.N(8), .MAX_LEN(16)) bus_a ();
  snake_move_ctrl_if #(.N(8), .MAX_LEN(4))  bus_b ();
  snake_move_ctrl_if #(.N(8), .MAX_LEN(16)) bus_c ();

  snake_move_ctrl #(.N(8), .MAX_LEN(16), .INIT_LEN(3), .TICK_DIV(4),
                    .START_X(2), .START_Y(2)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a));

  snake_move_ctrl #(.N(8), .MAX_LEN(4), .INIT_LEN(4), .TICK_DIV(4),
                    .START_X(2), .START_Y(2)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  snake_move_ctrl #(.N(8), .MAX_LEN(16), .INIT_LEN(3), .TICK_DIV(4),
                    .START_X(0), .START_Y(3)) u_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  typedef struct {
    logic [7:0] head;
    logic       grow;
    logic [4:0] len;
  } move_t;

  move_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next shift_en on instance A and score it against the queue.
  task automatic collect_a(input string name, input int want_gap);
    int n;
    move_t m;
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus_a.shift_en !== 1'b1 && n < 20);
    checks++;
    if (bus_a.shift_en !== 1'b1) begin
      errors++;
      $display("FAIL %s: no shift_en within %0d cycles", name, n);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected shift_en, head=%h", name, bus_a.head_out);
    end else begin
      m = exp_q.pop_front();
      if (bus_a.head_out !== m.head) begin
        errors++;
        $display("FAIL %s head: got %h want %h", name, bus_a.head_out, m.head);
      end
      checks++;
      if (bus_a.grow !== m.grow) begin
        errors++;
        $display("FAIL %s grow: got %b want %b", name, bus_a.grow, m.grow);
      end
      checks++;
      if (bus_a.length !== m.len) begin
        errors++;
        $display("FAIL %s length: got %0d want %0d", name, bus_a.length, m.len);
      end
      if (want_gap > 0) begin
        checks++;
        if (n != want_gap) begin
          errors++;
          $display("FAIL %s gap: got %0d cycles want %0d", name, n, want_gap);
        end
      end
    end
  endtask

  task automatic check_a_reset_vals(input string name);
    checks++;
    if (bus_a.head_out !== 8'h22 || bus_a.length !== 5'd3 || bus_a.shift_en !== 1'b0 ||
        bus_a.grow !== 1'b0 || bus_a.game_over !== 1'b0 || bus_a.running !== 1'b0) begin
      errors++;
      $display("FAIL %s: got head=%h len=%0d se=%b gr=%b go=%b run=%b want head=22 len=3 others 0",
               name, bus_a.head_out, bus_a.length, bus_a.shift_en, bus_a.grow,
               bus_a.game_over, bus_a.running);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    check_a_reset_vals("reset_a");
    checks++;
    if (bus_c.head_out !== 8'h03 || bus_b.length !== 3'd4) begin
      errors++;
      $display("FAIL reset_bc: got c.head=%h b.len=%0d want 03 4", bus_c.head_out, bus_b.length);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_moves_and_dir();
    bus_a.food_pos = 8'hFF;
    exp_q.push_back('{8'h32, 1'b0, 5'd3});
    exp_q.push_back('{8'h42, 1'b0, 5'd3});
    exp_q.push_back('{8'h43, 1'b0, 5'd3});
    exp_q.push_back('{8'h53, 1'b0, 5'd3});
    bus_a.start = 1'b1;
    cyc();
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.running !== 1'b1) begin
      errors++;
      $display("FAIL run_enter: running got %b want 1", bus_a.running);
    end
    collect_a("move1", 4);
    collect_a("move2", 4);
    // reverse (left) ignored, then down accepted
    bus_a.dir_valid = 1'b1;
    bus_a.dir_in    = 2'b11;
    cyc();
    bus_a.dir_in    = 2'b10;
    cyc();
    bus_a.dir_valid = 1'b0;
    collect_a("dir_down", 2);
    // request on the tick cycle steers that tick
    cyc();
    cyc();
    cyc();
    bus_a.dir_valid = 1'b1;
    bus_a.dir_in    = 2'b01;
    collect_a("dir_on_tick", 1);
    bus_a.dir_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_food_and_reset_on_tick();
    bus_a.food_pos = 8'h32;
    exp_q.push_back('{8'h32, 1'b1, 5'd4});
    exp_q.push_back('{8'h42, 1'b0, 5'd4});
    bus_a.start = 1'b1;
    cyc();
    bus_a.start = 1'b0;
    collect_a("food_grow", 4);
    cyc();
    checks++;
    if (bus_a.shift_en !== 1'b0 || bus_a.grow !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: se=%b gr=%b want 0 0", bus_a.shift_en, bus_a.grow);
    end
    collect_a("after_food", 3);
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    check_a_reset_vals("reset_on_tick");
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_len_saturate();
    int n;
    logic [7:0] want;
    bus_b.food_pos = 8'h32;
    bus_b.start = 1'b1;
    cyc();
    bus_b.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      want = {4'(3 + k), 4'd2};
      bus_b.food_pos = want;
      n = 0;
      do begin
        cyc();
        n++;
      end while (bus_b.shift_en !== 1'b1 && n < 20);
      checks++;
      if (bus_b.shift_en !== 1'b1 || bus_b.grow !== 1'b1 || bus_b.length !== 3'd4 ||
          bus_b.head_out !== want) begin
        errors++;
        $display("FAIL len_sat[%0d]: se=%b gr=%b len=%0d head=%h want 1 1 4 %h",
                 k, bus_b.shift_en, bus_b.grow, bus_b.length, bus_b.head_out, want);
      end
    end
  endtask

  task automatic test_wall();
    int n;
    int pulses;
    bus_c.food_pos = 8'hFF;
    bus_c.start = 1'b1;
    cyc();
    bus_c.start = 1'b0;
    cyc();
    bus_c.dir_valid = 1'b1;
    bus_c.dir_in    = 2'b00;
    cyc();
    bus_c.dir_valid = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus_c.shift_en !== 1'b1 && n < 20);
    checks++;
    if (bus_c.shift_en !== 1'b1 || bus_c.head_out !== 8'h02) begin
      errors++;
      $display("FAIL wall_setup: se=%b head=%h want 1 02", bus_c.shift_en, bus_c.head_out);
    end
    bus_c.dir_valid = 1'b1;
    bus_c.dir_in    = 2'b11;
    cyc();
    bus_c.dir_valid = 1'b0;
`ifdef SNAKE_WRAP_EN
    n = 0;
    while (bus_c.shift_en !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (bus_c.shift_en !== 1'b1 || bus_c.head_out !== 8'hF2 || bus_c.game_over !== 1'b0) begin
      errors++;
      $display("FAIL wrap_left: se=%b head=%h go=%b want 1 f2 0",
               bus_c.shift_en, bus_c.head_out, bus_c.game_over);
    end
`else
    n = 0;
    pulses = 0;
    while (bus_c.game_over !== 1'b1 && n < 20) begin
      cyc();
      n++;
      if (bus_c.shift_en === 1'b1) pulses++;
    end
    checks++;
    if (bus_c.game_over !== 1'b1 || pulses != 0 || bus_c.head_out !== 8'h02 ||
        bus_c.running !== 1'b0) begin
      errors++;
      $display("FAIL wall_hit: go=%b pulses=%0d head=%h run=%b want 1 0 02 0",
               bus_c.game_over, pulses, bus_c.head_out, bus_c.running);
    end
    cyc();
    cyc();
    bus_c.start = 1'b1;
    cyc();
    bus_c.start = 1'b0;
    checks++;
    if (bus_c.head_out !== 8'h03 || bus_c.length !== 5'd3 || bus_c.running !== 1'b1 ||
        bus_c.game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart: head=%h len=%0d run=%b go=%b want 03 3 1 0",
               bus_c.head_out, bus_c.length, bus_c.running, bus_c.game_over);
    end
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus_c.shift_en !== 1'b1 && n < 20);
    checks++;
    if (bus_c.shift_en !== 1'b1 || bus_c.head_out !== 8'h13 || n != 4) begin
      errors++;
      $display("FAIL restart_move: se=%b head=%h gap=%0d want 1 13 4",
               bus_c.shift_en, bus_c.head_out, n);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.dir_in = 2'b00; bus_a.dir_valid = 1'b0; bus_a.food_pos = 8'hFF;
    bus_b.start = 1'b0; bus_b.dir_in = 2'b00; bus_b.dir_valid = 1'b0; bus_b.food_pos = 8'hFF;
    bus_c.start = 1'b0; bus_c.dir_in = 2'b00; bus_c.dir_valid = 1'b0; bus_c.food_pos = 8'hFF;
    test_reset();
    test_moves_and_dir();
    test_food_and_reset_on_tick();
    test_len_saturate();
    test_wall();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d moves left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_move_ctrl.md
# snake_move_ctrl

Sequencing controller for the snake body shift register. It divides `clk` into game ticks and latches player direction requests. On each tick it computes the next head coordinate and drives the shift register's `data_in`/`enable` pair with a one-cycle pulse. It also tracks snake length, detects food and wall events, and sits between the key/direction decoder and the body shift register in the game top level.

## Interface
- `N`, 8, bits per segment word; head word = {x[N/2-1:0], y[N/2-1:0]}
- `MAX_LEN`, 16, maximum snake length in segments (must match shift register depth)
- `INIT_LEN`, 3, length after reset/restart; 1 ≤ INIT_LEN ≤ MAX_LEN
- `TICK_DIV`, 25000000, `clk` cycles per game tick; ≥ 2
- `START_X`, 2, initial head x
- `START_Y`, 2, initial head y

- `clk`  in  1  system clock (CLOCK_50 at top level)
- `reset`  in  1  synchronous, active-high
- `start`  in  1  level; begins/restarts game from IDLE or DEAD
- `dir_in`  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- `dir_valid`  in  1  `dir_in` qualifier, sampled every cycle
- `food_pos`  in  N  current food coordinate, same packing as head
- `head_out`  out  N  new head word; drives shift register `data_in`
- `shift_en`  out  1  one-cycle move pulse; drives shift register `enable`
- `grow`  out  1  one-cycle pulse, coincident with `shift_en`, when the new head equals `food_pos`
- `length`  out  $clog2(MAX_LEN+1)  current segment count
- `game_over`  out  1  high while in DEAD
- `running`  out  1  high while in RUN

## Operation
- States: IDLE, RUN, DEAD.
  - IDLE → RUN on `start`.
  - RUN → DEAD on a wall hit.
  - DEAD → RUN on `start`, which re-initialises all outputs and registers to their reset values.
  - `start` in RUN is ignored.
- Tick counter: runs 0..TICK_DIV-1 in RUN only; held at 0 in IDLE/DEAD; clears on tick.
- Direction: `cur_dir` is the committed direction and `pend_dir` the pending one.
  - Any `dir_valid` in RUN whose `dir_in` is not the reverse of `cur_dir` loads `pend_dir`.
  - If several requests arrive in one tick period, the last legal one wins.
  - Reversal is judged against `cur_dir`, not `pend_dir`.
  - At each tick, `cur_dir` ← `pend_dir`.
- Next head is computed from `head_out` and `pend_dir`:
  - up: y-1
  - down: y+1
  - left: x-1
  - right: x+1
- On a tick with no wall hit:
  - `head_out` ← next head.
  - `shift_en` ← 1.
  - `grow` ← (next head == `food_pos`).
  - If grow and `length` < MAX_LEN, `length` increments; at MAX_LEN it saturates while `grow` still pulses.
- On a tick with a wall hit:
  - No `shift_en`.
  - `head_out` holds.
  - `game_over` ← 1 and the state moves to DEAD.
- Self-collision is not checked here; it belongs to the body comparator block.

## Timing
- Reset values:
  - state IDLE
  - `head_out` = {START_X, START_Y}
  - `length` = INIT_LEN
  - `cur_dir` = `pend_dir` = 01 (right)
  - `shift_en` = `grow` = `game_over` = `running` = 0
  - counter 0
- All outputs are registered.
- `shift_en`, `grow`, and the new `head_out` appear together on the edge after the counter reaches TICK_DIV-1. The shift register samples them on the following edge.
- `shift_en` and `grow` are exactly one cycle wide. The first move pulse occurs TICK_DIV cycles after the edge that enters RUN.
- A `dir_valid` on the same cycle the counter reaches TICK_DIV-1 is applied to this tick's move.
- `length` updates on the same edge as `grow`.
- `reset` mid-game overrides everything on that edge, including a coincident tick. No pulse is emitted.
- `start` and a tick on the same edge in DEAD: re-init wins and the counter restarts at 0.

## Configuration
- `SNAKE_WRAP_EN` defined: coordinates wrap modulo 2^(N/2) (x = 0 moving left → 2^(N/2)-1, etc.). A wall hit never occurs and DEAD is reachable only through the external design.
- `SNAKE_WRAP_EN` undefined: a move that would take x or y out of range (below 0 or above 2^(N/2)-1) is a wall hit, handled as described in Operation.

## Test plan
- Reset, then `start` with TICK_DIV=4 and defaults. Required response:
  - first `shift_en` 4 cycles after entering RUN
  - `head_out` = {3,2}, then {4,2} four cycles later
  - `length` = 3
- Within one tick period, `dir_valid` with 11 (left, reverse) then 10 (down). Required response: next `head_out` = y+1, x unchanged; the reverse request is ignored.
- `food_pos` = {3,2} before the first tick. Required response: `grow` = 1 with `shift_en`, `length` = 4; the next tick gives `grow` = 0.
- INIT_LEN = MAX_LEN = 4, feed food on every move. Required response: `length` stays 4 and `grow` still pulses.
- Without `SNAKE_WRAP_EN`, START_X = 0 and direction left. Required response: at the tick, `game_over` = 1, no `shift_en`, `head_out` holds {0,2}; a later `start` restores reset values and RUN.
- With `SNAKE_WRAP_EN`, the same stimulus. Required response: `head_out` = {15,2} and `shift_en` pulses. Also assert `reset` on a tick edge: no pulse, all outputs return to their reset values.
